// File: rtl/hack_arith_pkg.sv
// Shared types and constants for the Hack arithmetic library.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_arith_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic [1:0] {
        SDEC_IDLE = 2'd0,
        SDEC_RUN  = 2'd1,
        SDEC_DONE = 2'd2
    } sdec_state_t;

endpackage

// File: rtl/serial_decrementor_if.sv
// Request/result bundle for the bit-serial decrementor.
// Latency: n/a (wires only).
// Backpressure: start is only sampled while the block is not busy.
interface serial_decrementor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             underflow;

    modport master (
        output start, in,
        input  out, busy, done, underflow
    );

    modport slave (
        input  start, in,
        output out, busy, done, underflow
    );
endinterface

// File: rtl/decrement_bit_cell.sv
// One bit of a ripple-borrow decrement: difference bit and outgoing borrow.
// Latency: combinational.
// Backpressure: none.
module decrement_bit_cell (
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ bin;
    assign bout = bin & ~a;
endmodule

// File: rtl/serial_decrementor.sv
// Bit-serial in-1: one borrow-propagation step per clock, LSB first.
// Latency: WIDTH cycles; with SERIAL_DECREMENTOR_EARLY_STOP_EN, k+1 where k is the lowest set operand bit.
// Backpressure: start ignored while busy; a start in the done cycle is accepted (WIDTH+1 cycle throughput).
module serial_decrementor
    import hack_arith_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_decrementor_if.slave  bus
);
    localparam int K_W = $clog2(WIDTH);

`ifdef SERIAL_DECREMENTOR_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    sdec_state_t      state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             uf_q, uf_d;

    logic cell_d;
    logic cell_bout;
    logic last_bit;

    // Single shared cell, steered to the current bit by k.
    decrement_bit_cell u_cell (
        .a    (opnd_q[k_q]),
        .bin  (b_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (k_q == K_W'(WIDTH - 1));

    // Next-state and datapath: accept in IDLE/DONE, one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        out_d   = out_q;
        k_d     = k_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        uf_d    = uf_q;
        case (state_q)
            SDEC_IDLE, SDEC_DONE: begin
                busy_d  = 1'b0;
                state_d = SDEC_IDLE;
                if (bus.start) begin
                    opnd_d  = bus.in;
                    out_d   = bus.in;
                    k_d     = '0;
                    b_d     = 1'b1;
                    uf_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SDEC_RUN;
                end
            end
            SDEC_RUN: begin
                out_d[k_q] = cell_d;
                b_d        = cell_bout;
                k_d        = k_q + K_W'(1);
                // Once the borrow dies, the untouched upper bits already equal the operand.
                if (last_bit || (EARLY_STOP && !cell_bout)) begin
                    k_d     = '0;
                    uf_d    = cell_bout;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = SDEC_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = SDEC_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SDEC_IDLE;
            opnd_q  <= '0;
            out_q   <= '0;
            k_q     <= '0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            out_q   <= out_d;
            k_q     <= k_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underflow = uf_q;

endmodule

// File: tb/tb_serial_decrementor.sv
// Directed bench for serial_decrementor (WIDTH=16); expectations follow SERIAL_DECREMENTOR_EARLY_STOP_EN.
// Latency: checked per operation against hand-computed cycle counts.
// Backpressure: exercises ignored mid-run start and held-high back-to-back start.
module tb_serial_decrementor;
    localparam int W = 16;

`ifdef SERIAL_DECREMENTOR_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   lat;
    int   n;
    int   done_seen;

    serial_decrementor_if #(.WIDTH(W)) bus ();

    serial_decrementor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns half a cycle after the accepting edge.
    task automatic start_op(input logic [15:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = v;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles until done is seen, with a bound.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.done !== 1'b1 && cnt < 200);
    endtask

    task automatic run_op(input string tag, input logic [15:0] v, input logic [15:0] exp_out,
                          input logic exp_uf, input int exp_lat);
        int c;
        start_op(v);
        check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
        wait_done(c);
        check({tag, "_latency"}, 32'(c), 32'(exp_lat));
        check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
        check({tag, "_uf"}, 32'(bus.underflow), 32'(exp_uf));
        check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_out_hold"}, 32'(bus.out), 32'(exp_out));
        check({tag, "_uf_hold"}, 32'(bus.underflow), 32'(exp_uf));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        #12;
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_uf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("dec5", 16'h0005, 16'h0004, 1'b0, ES ? 1 : 16);
        run_op("dec0", 16'h0000, 16'hFFFF, 1'b1, 16);
        run_op("dec8000", 16'h8000, 16'h7FFF, 1'b0, 16);
        run_op("decA5A4", 16'hA5A4, 16'hA5A3, 1'b0, ES ? 3 : 16);

        // Start during RUN must not disturb the operand.
        start_op(16'h1234);
        repeat (ES ? 1 : 4) @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 16'hFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        lat += ES ? 2 : 5;
        check("ign_latency", 32'(lat), ES ? 32'd3 : 32'd16);
        check("ign_out", 32'(bus.out), 32'h1233);
        check("ign_uf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        check("ign_no_restart", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-run: outputs clear between edges, no done follows.
        start_op(16'h8000);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_out", 32'(bus.out), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_uf", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("arst_no_done", 32'(done_seen), 32'd0);
        run_op("dec1", 16'h0001, 16'h0000, 1'b0, ES ? 1 : 16);

        // Start held high: second operand taken in the done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 16'h0002;
        @(negedge clk);
        bus.in    = 16'h0003;
        wait_done(lat);
        check("b2b_lat1", 32'(lat), ES ? 32'd2 : 32'd16);
        check("b2b_out1", 32'(bus.out), 32'h0001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 200);
        bus.start = 1'b0;
        check("b2b_spacing", 32'(n), ES ? 32'd2 : 32'(W + 1));
        check("b2b_out2", 32'(bus.out), 32'h0002);
        check("b2b_uf2", 32'(bus.underflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
